// File: rtl/conv_window_ctrl.sv
// conv_window_ctrl: sequences a KxK sliding-window FIFO over one raster frame; optional window counter via CONV_WIN_COUNT_EN
module conv_window_ctrl #(
    parameter int IFM_SIZE    = 28,
    parameter int KERNAL_SIZE = 5,
    parameter int CNT_WIDTH   = 5
`ifdef CONV_WIN_COUNT_EN
    ,
    parameter int WCNT_WIDTH  = 10
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 pix_valid,
    output logic                 pix_ready,
    output logic                 fifo_enable,
    output logic                 win_valid,
    input  logic                 win_ready,
    output logic [CNT_WIDTH-1:0] win_row,
    output logic [CNT_WIDTH-1:0] win_col,
    output logic                 busy,
    output logic                 done
`ifdef CONV_WIN_COUNT_EN
    ,
    output logic [WCNT_WIDTH-1:0] win_count
`endif
);
    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(IFM_SIZE - 1);
    localparam logic [CNT_WIDTH-1:0] KM1  = CNT_WIDTH'(KERNAL_SIZE - 1);
    state_t               state;
    logic [CNT_WIDTH-1:0] row;
    logic [CNT_WIDTH-1:0] col;
    // a pixel is taken only while running and the presented window is free or leaving
    always_comb begin
        pix_ready   = (state == RUN) && (!win_valid || win_ready);
        fifo_enable = pix_valid && pix_ready;
    end
    // frame FSM, pixel position tracking and the window flag that lines up with the FIFO taps
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            row       <= '0;
            col       <= '0;
            win_valid <= 1'b0;
            win_row   <= '0;
            win_col   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state <= RUN;
                    busy  <= 1'b1;
                    row   <= '0;
                    col   <= '0;
                end
                RUN: if (fifo_enable) begin
                    col <= (col == LAST) ? '0 : col + 1'b1;
                    row <= (col == LAST) ? row + 1'b1 : row;
                    if (row == LAST && col == LAST) state <= FLUSH;
                end
                FLUSH: if (win_valid && win_ready) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
            if (fifo_enable) begin
                win_valid <= (row >= KM1) && (col >= KM1);
                win_row   <= row - KM1;
                win_col   <= col - KM1;
            end else if (win_ready) begin
                win_valid <= 1'b0;
            end
        end
    end
`ifdef CONV_WIN_COUNT_EN
    // saturating count of windows handed to the MAC in the current frame
    always_ff @(posedge clk) begin
        if (reset || (state == IDLE && start)) win_count <= '0;
        else if (win_valid && win_ready && !(&win_count)) win_count <= win_count + 1'b1;
    end
`endif
endmodule

// File: tb/tb_conv_window_ctrl.sv
// tb_conv_window_ctrl: randomized and directed checks of conv_window_ctrl at 6/3 and at the 28/5 defaults
module tb_conv_window_ctrl;
    localparam int N = 6;
    localparam int K = 3;
    localparam int M = N - K + 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0, pix_valid = 1'b0, win_ready = 1'b0;
    logic pix_ready, fifo_enable, win_valid, busy, done;
    logic [2:0] win_row, win_col;
    logic b_start = 1'b0, b_pv = 1'b0, b_wr = 1'b0;
    logic b_pr, b_fe, b_wv, b_busy, b_done;
    logic [4:0] b_row, b_col;
`ifdef CONV_WIN_COUNT_EN
    logic [4:0] a_cnt;
    logic [9:0] b_cnt;
`endif

    int tests = 0, fails = 0;
    int m_st = 0, m_p = 0, m_wr = 0, m_wc = 0, m_nwin = 0, first_at = -1;
    bit m_wv = 1'b0, m_done = 1'b0;

    always #5 clk = ~clk;

    conv_window_ctrl #(.IFM_SIZE(N), .KERNAL_SIZE(K), .CNT_WIDTH(3)
`ifdef CONV_WIN_COUNT_EN
        , .WCNT_WIDTH(5)
`endif
    ) dut (
        .clk(clk), .reset(reset), .start(start), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .fifo_enable(fifo_enable), .win_valid(win_valid), .win_ready(win_ready),
        .win_row(win_row), .win_col(win_col), .busy(busy), .done(done)
`ifdef CONV_WIN_COUNT_EN
        , .win_count(a_cnt)
`endif
    );

    conv_window_ctrl dut_big (
        .clk(clk), .reset(reset), .start(b_start), .pix_valid(b_pv), .pix_ready(b_pr),
        .fifo_enable(b_fe), .win_valid(b_wv), .win_ready(b_wr),
        .win_row(b_row), .win_col(b_col), .busy(b_busy), .done(b_done)
`ifdef CONV_WIN_COUNT_EN
        , .win_count(b_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // one cycle: drive at the falling edge, check, then advance the reference model across the rising edge
    task automatic step(input bit pv, input bit wr, input bit st);
        bit exp_pr, sh, acc, was_idle, was_flush;
        int r, c;
        pix_valid = pv;
        win_ready = wr;
        start = st;
        #1;
        exp_pr = (m_st == 1) && (!m_wv || wr);
        chk("pix_ready", pix_ready, exp_pr);
        chk("fifo_enable", fifo_enable, pv && exp_pr);
        chk("win_valid", win_valid, m_wv);
        chk("busy", busy, m_st != 0);
        chk("done", done, m_done);
        if (m_wv) begin
            chk("win_row", win_row, m_wr);
            chk("win_col", win_col, m_wc);
        end
        if (m_wv && wr) begin
            chk("order_row", win_row, m_nwin / M);
            chk("order_col", win_col, m_nwin % M);
            m_nwin++;
        end
        if (win_valid === 1'b1 && first_at < 0) first_at = m_p;
        sh = pv && exp_pr;
        acc = m_wv && wr;
        was_idle = (m_st == 0);
        was_flush = (m_st == 2);
        m_done = 1'b0;
        if (sh) begin
            r = m_p / N;
            c = m_p % N;
            m_wv = (r >= K - 1) && (c >= K - 1);
            m_wr = r - K + 1;
            m_wc = c - K + 1;
            m_p++;
            if (m_p == N * N) m_st = 2;
        end else if (wr) begin
            m_wv = 1'b0;
        end
        if (was_flush && acc) begin
            m_st = 0;
            m_done = 1'b1;
        end
        if (was_idle && st) begin
            m_st = 1;
            m_p = 0;
            m_nwin = 0;
            first_at = -1;
        end
        @(negedge clk);
    endtask

    task automatic frame_tail(input int pv_pct, input int wr_pct, input int st_pct);
        for (int i = 0; i < 4000 && !m_done; i++)
            step($urandom_range(99) < pv_pct, $urandom_range(99) < wr_pct, $urandom_range(99) < st_pct);
        chk("frame_end", m_done, 1);
        chk("win_total", m_nwin, M * M);
`ifdef CONV_WIN_COUNT_EN
        chk("a_win_count", a_cnt, M * M);
`endif
    endtask

    task automatic run_frame(input int pv_pct, input int wr_pct, input int st_pct);
        step(1'b1, 1'b1, 1'b1);
        frame_tail(pv_pct, wr_pct, st_pct);
    endtask

    initial begin
        int sh, nw, fb;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_win_valid", win_valid, 0);
        chk("rst_win_row", win_row, 0);
        chk("rst_win_col", win_col, 0);
        chk("rst_pix_ready", pix_ready, 0);
        chk("rst_big_busy", b_busy, 0);
        @(negedge clk);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);

        run_frame(100, 100, 0);
        chk("first_window_shift", first_at, K * N - N + K);

        step(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 100 && !m_wv; i++) step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b0);
            chk("bp_valid", win_valid, 1);
            chk("bp_row", win_row, 0);
            chk("bp_col", win_col, 0);
        end
        frame_tail(100, 100, 0);

        step(1'b1, 1'b1, 1'b1);
        repeat (20) step(1'b1, 1'b1, 1'b0);
        chk("abort_pixels", m_p, 20);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_st = 0;
        m_wv = 1'b0;
        m_done = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_win_valid", win_valid, 0);
        chk("abort_done", done, 0);
        step(1'b1, 1'b1, 1'b0);
        chk("abort_no_done", done, 0);
        run_frame(100, 100, 0);
        chk("restart_first", first_at, K * N - N + K);

        run_frame(70, 60, 20);
        run_frame(50, 80, 30);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);

        sh = 0;
        nw = 0;
        fb = -1;
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        b_pv = 1'b1;
        b_wr = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            #1;
            if (b_done) break;
            if (b_wv && fb < 0) begin
                fb = sh;
                chk("big_first_row", b_row, 0);
                chk("big_first_col", b_col, 0);
            end
            if (b_wv && b_wr) nw++;
            if (b_fe) sh++;
            @(negedge clk);
        end
        chk("big_first_shift", fb, 117);
        chk("big_windows", nw, 576);
        chk("big_done", b_done, 1);
`ifdef CONV_WIN_COUNT_EN
        chk("big_win_count", b_cnt, 576);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
